// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters bursts of up to BURST_LEN beats on one FIFO write port.
// Optional per-requester beat counters on output beat_total when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         beat_total
`endif
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner, last_owner, rr_pick;
  logic [7:0]    beat_cnt;
  logic          last_beat;

  // Round-robin search: iterate from farthest to nearest so the nearest set bit after last_owner wins.
  always_comb begin
    rr_pick = last_owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (req[idx]) rr_pick = OW'(idx);
    end
  end

  assign last_beat = (beat_cnt == 8'(BURST_LEN - 1));

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) begin
        owner      <= rr_pick;
        last_owner <= rr_pick;
        beat_cnt   <= '0;
      end else if (state == BURST && fifo_wr_en) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // A dropped request ends the burst even while the FIFO is full.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = BURST;
      BURST: begin
        if (!req[owner])                   state_nxt = IDLE;
        else if (!fifo_full && last_beat)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack        = '0;
    grant      = '0;
    busy       = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == BURST) begin
      busy         = 1'b1;
      grant[owner] = 1'b1;
      fifo_wr_en   = req[owner] && !fifo_full;
      ack[owner]   = fifo_wr_en;
      fifo_din     = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beat_cnt_r [NUM_REQ];

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) beat_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (ack[i] && beat_cnt_r[i] != 16'hFFFF) beat_cnt_r[i] <= beat_cnt_r[i] + 16'd1;
    end
  end

  always_comb begin
    beat_total = '0;
    for (int i = 0; i < NUM_REQ; i++) beat_total[i*16 +: 16] = beat_cnt_r[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: transaction-level model compared every cycle plus literal write-sequence checks.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic            wr_clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            fifo_full;
  logic [N-1:0]    ack, grant;
  logic            busy, fifo_wr_en;
  logic [DW-1:0]   fifo_din;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] beat_total;
`endif

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string wlog  = "";

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(BL)) dut (
    .wr_clk(wr_clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .ack(ack), .grant(grant), .busy(busy), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din)
`ifdef FIFO_ARB_STATS_EN
    , .beat_total(beat_total)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input string exp);
    total++;
    if (wlog != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", nm, wlog, exp);
    end
  endtask

  // One cycle of stimulus; each requester word encodes its index and the cycle number.
  task automatic step(input logic [N-1:0] r, input logic f);
    req       = r;
    fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {i[3:0], cyc[3:0]};
    cyc++;
    @(posedge wr_clk);
    #1;
  endtask

  // Model: "burst in progress" with owner and beats written so far; checked at every falling edge.
  bit            m_busy  = 0;
  int            m_own   = 0;
  int            m_beats = 0;
  int            m_last  = N - 1;
  int            m_cnt [N];
  logic [N-1:0]  e_ack, e_grant;
  logic          e_busy, e_we;
  logic [DW-1:0] e_din;

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    forever begin
      @(negedge wr_clk);
      e_ack = '0; e_grant = '0; e_busy = 0; e_we = 0; e_din = '0;
      if (rst) begin
        m_busy = 0; m_beats = 0; m_last = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (m_busy) begin
        e_busy         = 1;
        e_grant[m_own] = 1'b1;
        e_we           = req[m_own] && !fifo_full;
        e_ack[m_own]   = e_we;
        e_din          = req_data[m_own*DW +: DW];
      end
      chk("ack", 32'(ack), 32'(e_ack));
      chk("grant", 32'(grant), 32'(e_grant));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_we));
      chk("fifo_din", 32'(fifo_din), 32'(e_din));
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk($sformatf("beat_total[%0d]", i), 32'(beat_total[i*16 +: 16]), 32'(m_cnt[i]));
      for (int i = 0; i < N; i++) if (e_ack[i] && m_cnt[i] < 65535) m_cnt[i]++;
`endif
      if (fifo_wr_en) begin
        int k;
        k = -1;
        for (int i = 0; i < N; i++) if (ack[i]) k = i;
        wlog = (k < 0) ? {wlog, "?"} : {wlog, $sformatf("%0d", k)};
      end else begin
        wlog = {wlog, "."};
      end
      if (!rst) begin
        if (!m_busy) begin
          if (req != '0) begin
            for (int k = 1; k <= N; k++)
              if (req[(m_last + k) % N]) begin
                m_own = (m_last + k) % N;
                break;
              end
            m_last  = m_own;
            m_busy  = 1;
            m_beats = 0;
          end
        end else if (!req[m_own]) begin
          m_busy = 0;
        end else if (e_we) begin
          m_beats++;
          if (m_beats == BL) m_busy = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;
    repeat (3) @(posedge wr_clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // All requesting: rotation 0,1,2,3 with one idle cycle before each burst.
    wlog = "";
    repeat (20) step(4'b1111, 1'b0);
    chk_log("rotate_all", ".0000.1111.2222.3333");
    step(4'b0000, 1'b0);

    // Only requester 2 with 10 words: bursts of 4, 4, 2.
    wlog = "";
    repeat (13) step(4'b0100, 1'b0);
    chk_log("single_req2", ".2222.2222.22");
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Owner 1 stalled by fifo_full for 3 cycles after 2 beats.
    wlog = "";
    repeat (3) step(4'b0010, 1'b0);
    repeat (3) step(4'b0010, 1'b1);
    chk("stall_grant", 32'(grant), 32'h2);
    repeat (2) step(4'b0010, 1'b0);
    chk_log("full_stall", ".11...11");
    step(4'b0000, 1'b0);

    // Owner 3 drops after 1 beat; requester 0 wins next by wrap.
    wlog = "";
    repeat (2) step(4'b1000, 1'b0);
    repeat (6) step(4'b0001, 1'b0);
    chk_log("drop_wrap", ".3..0000");
    step(4'b0000, 1'b0);

    // Reset during beat 2 of owner 2; requester 0 first afterwards.
    wlog = "";
    repeat (2) step(4'b0100, 1'b0);
    rst = 1'b1;
    repeat (2) step(4'b0100, 1'b0);
    rst = 1'b0;
    repeat (2) step(4'b1111, 1'b0);
    chk_log("rst_midburst", ".2...0");

`ifdef FIFO_ARB_STATS_EN
    rst = 1'b1;
    repeat (2) step(4'b0000, 1'b0);
    rst = 1'b0;
    wlog = "";
    repeat (15) step(4'b0010, 1'b0);
    chk_log("stats_bursts", ".1111.1111.1111");
    step(4'b0000, 1'b0);
    chk("stats_slice1", 32'(beat_total[31:16]), 32'd12);
    chk("stats_others", 32'({beat_total[63:32], beat_total[15:0]}), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each requester data word and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FIFO write port (2..16).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats written per grant (1..255).
REQ-004 wr_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester request; bit i asserted while requester i holds a valid word.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ack  output  NUM_REQ  one-hot; ack[i]=1 means requester i's word is written this cycle.
REQ-009 grant  output  NUM_REQ  registered one-hot owner; all zero when idle.
REQ-010 busy  output  1  high while in BURST state.
REQ-011 fifo_wr_en  output  1  write strobe to FIFO write port.
REQ-012 fifo_din  output  DATA_WIDTH  write data to FIFO.
REQ-013 fifo_full  input  1  FIFO full flag, same clock domain as wr_clk.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BURST.
REQ-015 In IDLE with req != 0, SHALL select owner by round-robin: first set req bit searching upward from last_owner+1, wrapping NUM_REQ-1 -> 0; then go to BURST, beat count = 0, last_owner = owner.
REQ-016 IDLE SHALL perform no write; arbitration latency is 1 cycle from req to first possible beat.
REQ-017 In BURST, fifo_wr_en SHALL be combinationally req[owner] && !fifo_full.
REQ-018 fifo_din SHALL equal the owner's req_data slice in BURST, and all zero in IDLE.
REQ-019 ack[owner] SHALL equal fifo_wr_en; all other ack bits are 0.
REQ-020 On each beat, the beat count SHALL increment; on the beat where count == BURST_LEN-1, FSM SHALL return to IDLE.
REQ-021 If req[owner] is low in BURST, FSM SHALL return to IDLE that cycle with no write.
REQ-022 fifo_full high in BURST SHALL stall: no write, no count change, and the owner keeps the grant.
REQ-023 If req[owner] drops while fifo_full is high, REQ-021 SHALL take precedence.
REQ-024 Requesters other than owner SHALL never be acked during a burst, regardless of their req.
REQ-025 With all requesters continuously requesting, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0,... with no requester skipped.
REQ-026 Requests arriving at the cycle FSM returns to IDLE SHALL be considered in the next IDLE cycle.

Reset
REQ-027 On rst, FSM SHALL enter IDLE; beat count 0; last_owner = NUM_REQ-1, so requester 0 wins first.
REQ-028 During and after rst, outputs SHALL be: grant=0, ack=0, busy=0, fifo_wr_en=0, fifo_din=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately; no write occurs while rst is high.

Configuration
REQ-030 Macro FIFO_ARB_STATS_EN defined: SHALL add output beat_total (NUM_REQ*16), with per-requester 16-bit beat counters at [i*16 +: 16].
REQ-031 Each beat counter SHALL increment on ack[i], saturate at 16'hFFFF, and reset to 0.
REQ-032 Macro FIFO_ARB_STATS_EN undefined: the beat_total port and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset release, req=4'b1111, fifo_full=0, BURST_LEN=4 -> idle cycle, then 4 beats to req 0, idle, then 4 beats to req 1, etc.
REQ-034 Only req[2] high, 10 words -> bursts of 4, 4, 2 to requester 2, each preceded by 1 idle cycle; fifo_din matches slice 2.
REQ-035 Owner 1 mid-burst after 2 beats, fifo_full=1 for 3 cycles -> no ack for 3 cycles; grant stays 4'b0010; 2 remaining beats follow.
REQ-036 Owner 3 drops req after 1 beat while req[0] is high -> FSM goes to IDLE, next grant goes to 0 (wrap), with no write on the drop cycle.
REQ-037 rst pulsed during beat 2 of owner 2 -> outputs zero asynchronously; after release, requester 0 wins first.
REQ-038 FIFO_ARB_STATS_EN defined, 3 full bursts to requester 1 -> beat_total slice 1 = 12, other slices = 0.
